// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and timing constant for the divide sequencer
package div_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        FIX
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional 32-bit two's-complement negate
module div_sign_fix (
    input  logic [31:0] a,
    input  logic        neg,
    output logic [31:0] y
);

    assign y = neg ? (~a + 32'd1) : a;

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - DIV/DIVU sequencer around the shift-subtract core, owns HI/LO
module div_ctrl
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        dv_reset,
    output logic [31:0] dv_a,
    output logic [31:0] dv_b,
    input  logic [31:0] dv_lo,
    input  logic [31:0] dv_hi,
    input  logic [5:0]  dv_counter
);

    localparam logic [5:0] COUNT_DONE = 6'(DIV_CYCLES);

    div_state_t  state;
    div_state_t  state_next;
    logic        neg_q;
    logic        neg_r;
    logic        idle;
    logic        rt_zero;
    logic        launch;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] fix_lo;
    logic [31:0] fix_hi;

    assign idle    = (state == IDLE);
    assign rt_zero = (rt_val == 32'd0);
    assign launch  = idle & start & ~rt_zero;
    assign busy    = ~idle;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    div_sign_fix u_mag_a (.a(rs_val), .neg(is_signed & rs_val[31]), .y(mag_a));
    div_sign_fix u_mag_b (.a(rt_val), .neg(is_signed & rt_val[31]), .y(mag_b));
    div_sign_fix u_fix_lo (.a(dv_lo), .neg(neg_q), .y(fix_lo));
    div_sign_fix u_fix_hi (.a(dv_hi), .neg(neg_r), .y(fix_hi));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (dv_counter == COUNT_DONE) state_next = DRAIN;
            DRAIN:   state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            hi_out   <= 32'd0;
            lo_out   <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            dv_reset <= 1'b1;
            dv_a     <= 32'd0;
            dv_b     <= 32'd1;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= (state == FIX);
            div_zero <= idle & start & rt_zero;
            // registered so the core sees the load strobe during the LOAD cycle itself
            dv_reset <= (state_next == LOAD);
            if (launch) begin
                neg_q <= is_signed & (rs_val[31] ^ rt_val[31]);
                neg_r <= is_signed & rs_val[31];
                dv_a  <= mag_a;
                dv_b  <= mag_b;
            end
            if (idle && mthi_we) hi_out <= wdata;
            if (idle && mtlo_we) lo_out <= wdata;
            if (state == FIX) begin
                lo_out <= fix_lo;
                hi_out <= fix_hi;
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed and randomized checks of div_ctrl against an arithmetic model
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd1;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        dv_reset;
    logic [31:0] dv_a;
    logic [31:0] dv_b;
    logic [31:0] dv_lo = 32'd0;
    logic [31:0] dv_hi = 32'd0;
    logic [5:0]  dv_counter = 6'd0;

    logic [31:0] core_a = 32'd0;
    logic [31:0] core_b = 32'd1;

    int checks = 0;
    int failures = 0;

    div_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .rs_val(rs_val), .rt_val(rt_val), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
        .div_zero(div_zero), .dv_reset(dv_reset), .dv_a(dv_a), .dv_b(dv_b),
        .dv_lo(dv_lo), .dv_hi(dv_hi), .dv_counter(dv_counter)
    );

    always #5 clk = ~clk;

    // Divider core stand-in: counter is 1-based (iteration in progress), saturates at 32,
    // and the result lands in LO/HI on the edge after the count completes.
    always @(posedge clk) begin
        if (dv_reset) begin
            core_a     <= dv_a;
            core_b     <= dv_b;
            dv_counter <= 6'd1;
        end else if (dv_counter < 6'd32) begin
            dv_counter <= dv_counter + 6'd1;
        end else begin
            dv_lo <= core_a / core_b;
            dv_hi <= core_a % core_b;
        end
    end

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (sg) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launches a divide and checks the whole busy/done timeline; inj>0 pokes start+MTLO mid-flight.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int inj);
        logic [63:0] e;
        int bad;
        e = ref_div(sg, a, b);
        @(negedge clk);
        start = 1'b1; is_signed = sg; rs_val = a; rt_val = b;
        bad = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            start = 1'b0; mtlo_we = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0 || lo_out === 32'h1234) bad++;
            if (i == inj) begin
                start = 1'b1; is_signed = 1'b0; rs_val = 32'd9; rt_val = 32'd3;
                mtlo_we = 1'b1; wdata = 32'h1234;
            end
        end
        chk({tag, "_busy_window"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_lo"}, lo_out, e[31:0]);
        chk({tag, "_hi"}, hi_out, e[63:32]);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'd0, done, div_zero}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic rsg;
        int bad;

        repeat (2) @(negedge clk);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
        chk("rst_dv_a", dv_a, 32'd0);
        chk("rst_dv_b", dv_b, 32'd1);
        chk("rst_dv_reset", {31'd0, dv_reset}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        chk("divu_100_7_lo_const", lo_out, 32'd14);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_m7_2_hi_const", hi_out, 32'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        chk("div_7_m2_lo_const", lo_out, 32'hFFFF_FFFD);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_lo_const", lo_out, 32'h8000_0000);

        // MTHI/MTLO then divide by zero
        @(negedge clk);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'hAAAA;
        @(negedge clk);
        mthi_we = 1'b0; wdata = 32'h5555;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mt_hi", hi_out, 32'hAAAA);
        chk("mt_lo", lo_out, 32'h5555);
        start = 1'b1; is_signed = 1'b1; rs_val = 32'd42; rt_val = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("dz_pulse", {29'd0, busy, done, div_zero}, 32'd1);
        @(negedge clk);
        chk("dz_after", {29'd0, busy, done, div_zero}, 32'd0);
        chk("dz_hi_kept", hi_out, 32'hAAAA);
        chk("dz_lo_kept", lo_out, 32'h5555);

        // reset in the middle of a divide
        start = 1'b1; is_signed = 1'b0; rs_val = 32'd1000; rt_val = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        run_div("divu_1000_3", 1'b0, 32'd1000, 32'd3, 0);
        chk("divu_1000_3_lo_const", lo_out, 32'd333);

        // start and MTLO while busy are ignored
        run_div("busy_ignore", 1'b0, 32'd50, 32'd6, 5);

        // MTHI in the launch cycle commits, then the divide overwrites it
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; rs_val = 32'd77; rt_val = 32'd10;
        mthi_we = 1'b1; wdata = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; mthi_we = 1'b0;
        chk("same_cycle_mthi", hi_out, 32'hBEEF);
        repeat (35) @(negedge clk);
        chk("same_cycle_done", {31'd0, done}, 32'd1);
        chk("same_cycle_hi", hi_out, 32'd7);
        chk("same_cycle_lo", lo_out, 32'd7);

        for (int n = 0; n < 8; n++) begin
            rsg = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (n % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rb == 32'd0) rb = 32'd5;
            run_div($sformatf("rand%0d", n), rsg, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer between the decode/control unit and the 32-cycle unsigned divider (shift-subtract core with ports A, B, LO, HI, div0, counter).
- Accepts DIV/DIVU requests and converts signed operands to magnitudes.
- Launches the core, waits for it to finish, sign-corrects the quotient and remainder, and commits them to the architectural HI/LO registers.
- Also owns MTHI/MTLO writes and the pipeline stall while a divide is in flight.

Parameters:
- DIV_CYCLES, 32, iterations the divider core runs before its result becomes valid.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- start  in  1  one-cycle divide request; sampled only in IDLE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU
- rs_val  in  32  dividend
- rt_val  in  32  divisor
- mthi_we  in  1  write wdata into HI
- mtlo_we  in  1  write wdata into LO
- wdata  in  32  MTHI/MTLO data
- hi_out  out  32  architectural HI (remainder)
- lo_out  out  32  architectural LO (quotient)
- busy  out  1  stall request to pipeline
- done  out  1  one-cycle pulse when HI/LO are updated by a divide
- div_zero  out  1  one-cycle pulse, divisor was zero
- dv_reset  out  1  active-high load/reset to divider core
- dv_a  out  32  unsigned dividend to core
- dv_b  out  32  unsigned divisor to core
- dv_lo  in  32  core quotient
- dv_hi  in  32  core remainder
- dv_counter  in  6  core iteration counter

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_zero=0, dv_a=0, dv_b=1.
- dv_reset = (~reset) | (state==LOAD). It is registered, so the core is held cleared during reset.
- Reset mid-operation aborts the divide, leaves HI/LO at 0, and emits no done.
- States: IDLE -> LOAD -> RUN -> DRAIN -> FIX -> IDLE.
- IDLE, start=1, rt_val==0:
  - No launch; HI/LO unchanged.
  - div_zero=1 and done=0 in the next cycle; stays in IDLE.
  - The core's div0 output is not used.
- IDLE, start=1, rt_val!=0:
  - Latch the negative-quotient flag neg_q = is_signed & (rs[31]^rt[31]).
  - Latch the negative-remainder flag neg_r = is_signed & rs[31].
  - dv_a=|rs| and dv_b=|rt| when is_signed, else raw values; next state LOAD.
  - |0x80000000| = 0x80000000, taken as unsigned.
- LOAD: one cycle with dv_reset=1; next state RUN.
- RUN: wait until dv_counter==DIV_CYCLES; next state DRAIN.
- DRAIN: one cycle while the core writes LO/HI; next state FIX.
- FIX:
  - lo_out <= neg_q ? -dv_lo : dv_lo.
  - hi_out <= neg_r ? -dv_hi : dv_hi.
  - Widths are mod 2^32; next state IDLE.
- Latency: start sampled at cycle T.
  - busy=1 for cycles T+1..T+35.
  - done=1 in cycle T+36, with hi_out/lo_out already showing the new values.
  - A new start is accepted in cycle T+36.
- start while busy: ignored (no queueing).
- mthi_we/mtlo_we in IDLE: write on the next edge. While busy: ignored.
- start and mt*_we in the same IDLE cycle: the MT write commits and the divide is also launched. The divide result later overwrites both registers.
- Overflow -2^31 / -1: LO=0x80000000, HI=0, no exception.
- done and div_zero are never high simultaneously.

Decomposition:
- Package div_pkg: state enum (IDLE, LOAD, RUN, DRAIN, FIX) and constant DIV_CYCLES=32.
- Sub-module div_sign_fix (combinational): conditional two's-complement negate, 32-bit. It is instantiated for the operand magnitudes and for the result correction.

Test Plan:
- DIVU rs=100, rt=7, start at T -> busy T+1..T+35; done at T+36; lo_out=14, hi_out=2.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Then rs=7, rt=-2 -> lo=-3, hi=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, no div_zero.
- start with rt=0 after MTHI 0xAAAA/MTLO 0x5555 -> div_zero pulse next cycle; busy stays 0; HI/LO still 0xAAAA/0x5555.
- Launch DIVU 1000/3, pull reset low at T+10 for one cycle -> hi_out=lo_out=0, busy=0, no done. A fresh start then gives lo=333, hi=1.
- During busy: pulse start (rs=9, rt=3) and mtlo_we (wdata=0x1234) -> both ignored; the in-flight result commits unchanged; lo_out never equals 0x1234.
